a_bus_arbiter: RTL and testbench
================================

// Module: a_bus_arbiter
// PURPOSE
//  Two-master serial-bus arbiter. It grants the bus to master 0 (high priority) or master 1 (low priority).
//  It consumes the thresh flag of the upstream slave-ready threshold counter.
//  When the granted M0 stalls on a slow slave past the threshold, the bus is split: M0 is parked and M1 is
//  granted until it finishes or a split limit expires. The bus then returns to M0.
// PARAMETERS
//  GAP         1    dead (no-grant) turnaround cycles between any two grants; 0 = direct handover
//  SPLIT_LIMIT 256  max cycles M1 may hold the bus during a split (>=1)
// PORTS
//  clk          in   1  single clock, all logic on posedge
//  rst          in   1  asynchronous, active-high reset
//  req          in   2  bus request; bit0 = M0 (high), bit1 = M1 (low)
//  done         in   2  1-cycle release pulse from the currently granted master
//  thresh       in   1  slave-ready delay exceeded (from threshold counter)
//  slave_ready  in   1  addressed slave of parked M0 has data ready
//  grant        out  2  one-hot grant, registered; 2'b00 = bus idle/gap
//  split        out  1  high while M0 is parked (gap in, SPLIT state, gap out)
//  resume       out  1  1-cycle pulse on first cycle of M0 re-grant after a split
//  ready_pend   out  1  slave_ready seen while M0 was parked; cleared with resume
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; grant=00, split=0, resume=0, ready_pend=0; counters=0.
//  - All outputs are registered. A grant appears 1 cycle after the deciding input is sampled.
//  - States: IDLE, GNT0, GNT1, SPLIT, GAPW (gap wait; holds next-state and a gap counter).
//  - Any transition between grants passes through GAPW for exactly GAP cycles with grant=00.
//    With GAP=0, GAPW is skipped.
//  - IDLE: req[0] -> GNT0; else req[1] -> GNT1; else stay. A simultaneous request goes to M0.
//  - GNT0: done[0] -> (GAPW) -> IDLE.
//    thresh && req[1] && !done[0] -> split=1, (GAPW) -> SPLIT.
//    done[0] wins over thresh in the same cycle.
//    thresh with !req[1]: stay in GNT0, no split.
//  - GNT1: done[1] -> (GAPW) -> IDLE. Non-preemptive: req[0] and thresh are ignored.
//  - SPLIT: grant=10 (M1). The split timer counts from 0 each cycle.
//    Exit on done[1] or when timer == SPLIT_LIMIT-1, whichever comes first:
//    (GAPW) -> GNT0 with resume=1 for that first GNT0 cycle; split drops in the same cycle.
//  - ready_pend: set on slave_ready while split=1; sticky; cleared in the cycle resume asserts.
//  - thresh is ignored outside GNT0. Re-splitting is allowed after resume if thresh re-asserts.
//  - done from a non-granted master, or during GAPW, is ignored.
//    req deassertion without done does not release the bus.
//  - Counters: gap counter ceil(log2(GAP+1)) bits; split timer ceil(log2(SPLIT_LIMIT)) bits.
//    Both counters saturate-free: they reload on state entry and never wrap mid-state.
//  - Invariant: grant is never 11. grant changes only via a GAPW (or direct when GAP=0).
// TESTING
//  1. GAP=1: req=01 at t0 -> grant=01 at t1; done[0] at t5 -> grant=00 t6, IDLE t7.
//  2. req=11 from IDLE -> grant=01. M0 done -> 00 for 1 cycle -> grant=10 (M1 served).
//  3. GNT0, req[1]=1, thresh=1 at t0 -> split=1 t1, grant=00 t1, grant=10 t2.
//     done[1] at t6 -> grant=00 t7, grant=01 + resume=1 t8, split=0 t8.
//  4. SPLIT_LIMIT=4, M1 never done -> grant=10 exactly 4 cycles.
//     Then gap, then M0 resumes. slave_ready pulse mid-split -> ready_pend=1 until resume cycle.
//  5. done[0] and thresh both high in GNT0 -> no split, bus released.
//     GNT1 with req[0]=1, thresh=1 -> M1 keeps grant until done[1].
//  6. rst asserted mid-SPLIT (async, off clock edge) -> grant=00, split=0, ready_pend=0 immediately.
//     After release, req=01 -> normal GNT0.

Source files
------------

// File: rtl/a_bus_arbiter.sv
// Two-master bus arbiter with split support.
// M0 (req[0]) has priority over M1 (req[1]). When the granted M0 stalls on a
// slow slave (thresh) and M1 is waiting, M0 is parked and M1 gets the bus for
// at most SPLIT_LIMIT cycles. After that the bus returns to M0 with a
// one-cycle resume pulse. Every change of grant passes through GAP dead
// cycles (GAPW) unless GAP is 0.
//
// Handshake: a master holds req high until it is granted. The granted master
// releases the bus with a 1-cycle done pulse. Dropping req without done does
// not release the bus. done from a master that is not granted is ignored, and
// so is done during GAPW.
module a_bus_arbiter #(
    parameter int GAP         = 1,
    parameter int SPLIT_LIMIT = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] done,
    input  logic       thresh,
    input  logic       slave_ready,
    output logic [1:0] grant,
    output logic       split,
    output logic       resume,
    output logic       ready_pend,
    output logic [2:0] dbg_state
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int SW = (SPLIT_LIMIT > 1) ? $clog2(SPLIT_LIMIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GNT0  = 3'd1,
        S_GNT1  = 3'd2,
        S_SPLIT = 3'd3,
        S_GAPW  = 3'd4
    } state_t;

    state_t          state;
    state_t          nxt_state;
    state_t          gap_tgt;
    state_t          gap_tgt_n;
    logic [GW-1:0]   gap_cnt;
    logic [SW-1:0]   split_tmr;
    logic            start_split;
    logic            resume_n;
    logic            split_n;
    logic [1:0]      grant_n;

    // Fixed-priority pick used from IDLE and when a gap ends with the bus free
    function automatic state_t arb(input logic [1:0] r);
        if (r[0]) begin
            return S_GNT0;
        end else if (r[1]) begin
            return S_GNT1;
        end
        return S_IDLE;
    endfunction

    // Next-state decision; all registered outputs are derived from it below
    always_comb begin
        nxt_state   = state;
        gap_tgt_n   = gap_tgt;
        start_split = 1'b0;
        case (state)
            S_IDLE: begin
                nxt_state = arb(req);
            end
            S_GNT0: begin
                // done[0] wins over thresh in the same cycle
                if (done[0]) begin
                    gap_tgt_n = S_IDLE;
                    nxt_state = (GAP == 0) ? arb(req) : S_GAPW;
                end else if (thresh && req[1]) begin
                    start_split = 1'b1;
                    gap_tgt_n   = S_SPLIT;
                    nxt_state   = (GAP == 0) ? S_SPLIT : S_GAPW;
                end
            end
            S_GNT1: begin
                // Non-preemptive: req[0] and thresh have no effect here
                if (done[1]) begin
                    gap_tgt_n = S_IDLE;
                    nxt_state = (GAP == 0) ? arb(req) : S_GAPW;
                end
            end
            S_SPLIT: begin
                if (done[1] || (split_tmr == SW'(SPLIT_LIMIT - 1))) begin
                    gap_tgt_n = S_GNT0;
                    nxt_state = (GAP == 0) ? S_GNT0 : S_GAPW;
                end
            end
            S_GAPW: begin
                // A gap that ends in IDLE arbitrates immediately so a waiting
                // master sees exactly GAP dead cycles
                if (gap_cnt == '0) begin
                    nxt_state = (gap_tgt == S_IDLE) ? arb(req) : gap_tgt;
                end
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // Output decode of the next state; entering GNT0 while parked is a resume
    always_comb begin
        resume_n = (nxt_state == S_GNT0) && split;
        split_n  = split;
        if (start_split) begin
            split_n = 1'b1;
        end else if (resume_n) begin
            split_n = 1'b0;
        end
        grant_n = 2'b00;
        if (nxt_state == S_GNT0) begin
            grant_n = 2'b01;
        end else if ((nxt_state == S_GNT1) || (nxt_state == S_SPLIT)) begin
            grant_n = 2'b10;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            gap_tgt    <= S_IDLE;
            gap_cnt    <= '0;
            split_tmr  <= '0;
            grant      <= 2'b00;
            split      <= 1'b0;
            resume     <= 1'b0;
            ready_pend <= 1'b0;
        end else begin
            state   <= nxt_state;
            gap_tgt <= gap_tgt_n;

            // Gap counter reloads on GAPW entry and counts down to zero
            if ((nxt_state == S_GAPW) && (state != S_GAPW)) begin
                gap_cnt <= GW'(GAP - 1);
            end else if (state == S_GAPW) begin
                gap_cnt <= gap_cnt - GW'(1);
            end

            // Split timer restarts at 0 on SPLIT entry
            if ((nxt_state == S_SPLIT) && (state != S_SPLIT)) begin
                split_tmr <= '0;
            end else if (state == S_SPLIT) begin
                split_tmr <= split_tmr + SW'(1);
            end

            grant  <= grant_n;
            split  <= split_n;
            resume <= resume_n;

            // Sticky while parked; the resume cycle clears it
            if (resume_n) begin
                ready_pend <= 1'b0;
            end else if (split && slave_ready) begin
                ready_pend <= 1'b1;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_a_bus_arbiter.sv
// Directed bench for a_bus_arbiter. Three instances share the inputs:
// default parameters, SPLIT_LIMIT=4, and GAP=0 with SPLIT_LIMIT=4.
module tb_a_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] done;
    logic       thresh;
    logic       slave_ready;

    logic [1:0] grant, grant4, grant0;
    logic       split, split4, split0;
    logic       resume, resume4, resume0;
    logic       ready_pend, ready_pend4, ready_pend0;
    logic [2:0] st, st4, st0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    a_bus_arbiter u_dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .thresh(thresh),
        .slave_ready(slave_ready), .grant(grant), .split(split),
        .resume(resume), .ready_pend(ready_pend), .dbg_state(st)
    );

    a_bus_arbiter #(.GAP(1), .SPLIT_LIMIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .done(done), .thresh(thresh),
        .slave_ready(slave_ready), .grant(grant4), .split(split4),
        .resume(resume4), .ready_pend(ready_pend4), .dbg_state(st4)
    );

    a_bus_arbiter #(.GAP(0), .SPLIT_LIMIT(4)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .done(done), .thresh(thresh),
        .slave_ready(slave_ready), .grant(grant0), .split(split0),
        .resume(resume0), .ready_pend(ready_pend0), .dbg_state(st0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 2'b00; done = 2'b00; thresh = 1'b0; slave_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({grant, split, resume, ready_pend} !== 5'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=%b", {grant, split, resume, ready_pend}, 5'b0); end
        checks++; if (st !== 3'd0) begin
            failures++; $display("FAIL reset_state got=%0d exp=0", st); end
    endtask

    task automatic test_basic();
        do_reset();
        req = 2'b01; tick();
        checks++; if (grant !== 2'b01) begin
            failures++; $display("FAIL basic_t1_grant got=%b exp=01", grant); end
        repeat (4) tick();
        checks++; if (grant !== 2'b01) begin
            failures++; $display("FAIL basic_t5_grant got=%b exp=01", grant); end
        done = 2'b01; req = 2'b00; tick(); done = 2'b00;
        checks++; if (grant !== 2'b00 || st !== 3'd4) begin
            failures++; $display("FAIL basic_t6_gap got=%b/%0d exp=00/4", grant, st); end
        tick();
        checks++; if (grant !== 2'b00 || st !== 3'd0) begin
            failures++; $display("FAIL basic_t7_idle got=%b/%0d exp=00/0", grant, st); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 2'b11; tick();
        checks++; if (grant !== 2'b01) begin
            failures++; $display("FAIL simul_grant got=%b exp=01", grant); end
        done = 2'b01; req = 2'b10; tick(); done = 2'b00;
        checks++; if (grant !== 2'b00) begin
            failures++; $display("FAIL simul_gap got=%b exp=00", grant); end
        tick();
        checks++; if (grant !== 2'b10 || st !== 3'd2) begin
            failures++; $display("FAIL simul_m1 got=%b/%0d exp=10/2", grant, st); end
    endtask

    task automatic test_split();
        do_reset();
        req = 2'b01; tick();
        req = 2'b11; thresh = 1'b1; tick(); thresh = 1'b0;
        checks++; if (split !== 1'b1 || grant !== 2'b00) begin
            failures++; $display("FAIL split_t1 got=%b/%b exp=1/00", split, grant); end
        tick();
        checks++; if (grant !== 2'b10 || split !== 1'b1) begin
            failures++; $display("FAIL split_t2 got=%b/%b exp=10/1", grant, split); end
        repeat (4) tick();
        checks++; if (grant !== 2'b10) begin
            failures++; $display("FAIL split_t6 got=%b exp=10", grant); end
        done = 2'b10; tick(); done = 2'b00;
        checks++; if (grant !== 2'b00 || split !== 1'b1) begin
            failures++; $display("FAIL split_t7 got=%b/%b exp=00/1", grant, split); end
        tick();
        checks++; if ({grant, resume, split} !== 4'b0110) begin
            failures++; $display("FAIL split_t8_resume got=%b exp=0110", {grant, resume, split}); end
        tick();
        checks++; if (resume !== 1'b0 || grant !== 2'b01) begin
            failures++; $display("FAIL split_t9 got=%b/%b exp=0/01", resume, grant); end
    endtask

    task automatic test_split_limit();
        do_reset();
        req = 2'b01; tick();
        req = 2'b11; thresh = 1'b1; tick(); thresh = 1'b0;
        tick();
        checks++; if (grant4 !== 2'b10 || ready_pend4 !== 1'b0) begin
            failures++; $display("FAIL limit_c1 got=%b/%b exp=10/0", grant4, ready_pend4); end
        slave_ready = 1'b1; tick(); slave_ready = 1'b0;
        checks++; if (grant4 !== 2'b10 || ready_pend4 !== 1'b1) begin
            failures++; $display("FAIL limit_c2 got=%b/%b exp=10/1", grant4, ready_pend4); end
        repeat (2) tick();
        checks++; if (grant4 !== 2'b10 || ready_pend4 !== 1'b1) begin
            failures++; $display("FAIL limit_c4 got=%b/%b exp=10/1", grant4, ready_pend4); end
        tick();
        checks++; if ({grant4, split4, ready_pend4} !== 4'b0011) begin
            failures++; $display("FAIL limit_gap got=%b exp=0011", {grant4, split4, ready_pend4}); end
        tick();
        checks++; if ({grant4, resume4, split4, ready_pend4} !== 5'b01100) begin
            failures++; $display("FAIL limit_resume got=%b exp=01100", {grant4, resume4, split4, ready_pend4}); end
    endtask

    task automatic test_priority();
        do_reset();
        req = 2'b11; tick();
        done = 2'b01; thresh = 1'b1; tick(); done = 2'b00; thresh = 1'b0;
        checks++; if (grant !== 2'b00 || split !== 1'b0) begin
            failures++; $display("FAIL prio_done_wins got=%b/%b exp=00/0", grant, split); end
        req = 2'b10; tick();
        checks++; if (grant !== 2'b10) begin
            failures++; $display("FAIL prio_m1 got=%b exp=10", grant); end
        req = 2'b11; thresh = 1'b1; repeat (3) tick(); thresh = 1'b0;
        checks++; if (grant !== 2'b10 || split !== 1'b0) begin
            failures++; $display("FAIL prio_nonpreempt got=%b/%b exp=10/0", grant, split); end
        done = 2'b10; req = 2'b01; tick(); done = 2'b00;
        checks++; if (grant !== 2'b00) begin
            failures++; $display("FAIL prio_gap got=%b exp=00", grant); end
        tick();
        checks++; if (grant !== 2'b01) begin
            failures++; $display("FAIL prio_m0 got=%b exp=01", grant); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 2'b01; tick();
        req = 2'b11; thresh = 1'b1; tick(); thresh = 1'b0;
        tick();
        slave_ready = 1'b1; tick(); slave_ready = 1'b0;
        checks++; if (ready_pend !== 1'b1 || grant !== 2'b10) begin
            failures++; $display("FAIL arst_pre got=%b/%b exp=1/10", ready_pend, grant); end
        #3 rst = 1'b1;
        #1;
        checks++; if ({grant, split, ready_pend} !== 4'b0000) begin
            failures++; $display("FAIL arst_immediate got=%b exp=0000", {grant, split, ready_pend}); end
        req = 2'b00;
        @(posedge clk); #1 rst = 1'b0;
        req = 2'b01; tick();
        checks++; if (grant !== 2'b01 || st !== 3'd1) begin
            failures++; $display("FAIL arst_regrant got=%b/%0d exp=01/1", grant, st); end
    endtask

    task automatic test_gap0();
        do_reset();
        req = 2'b11; tick();
        checks++; if (grant0 !== 2'b01) begin
            failures++; $display("FAIL gap0_m0 got=%b exp=01", grant0); end
        done = 2'b01; req = 2'b10; tick(); done = 2'b00;
        checks++; if (grant0 !== 2'b10) begin
            failures++; $display("FAIL gap0_direct got=%b exp=10", grant0); end
        done = 2'b10; req = 2'b01; tick(); done = 2'b00;
        checks++; if (grant0 !== 2'b01) begin
            failures++; $display("FAIL gap0_back got=%b exp=01", grant0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_simultaneous();
        test_split();
        test_split_limit();
        test_priority();
        test_async_reset();
        test_gap0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
